// File: rtl/overdrive_multi.sv
// overdrive_multi: per-channel overdrive stage with selectable pre-gain,
// hard/soft/bypass clipping and a slew-limited symmetric threshold.
//
// Handshake: in_valid is a one-cycle strobe qualifying input_frame. There is
// no backpressure; every strobed sample is accepted. out_valid is a one-cycle
// strobe that appears two clocks after the accepting edge. output_frame holds
// its last value between strobes.
module overdrive_multi #(
  parameter int WIDTH     = 16,
  parameter int MAX_SHIFT = 3,
  parameter int THR_RESET = 15000,
  parameter int RAMP_STEP = 256
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                in_valid,
  input  logic [WIDTH-1:0]                    input_frame,
  input  logic [$clog2(MAX_SHIFT+1)-1:0]      gain_shift,
  input  logic [1:0]                          mode,
  input  logic [WIDTH-2:0]                    threshold,
  output logic                                out_valid,
  output logic [WIDTH-1:0]                    output_frame,
  output logic                                ramping
);

  localparam int SW = $clog2(MAX_SHIFT + 1);
  localparam int GW = WIDTH + MAX_SHIFT;  // gained sample width, never wraps
  localparam int TW = WIDTH - 1;          // threshold / magnitude width

  localparam logic [TW-1:0] THR_INIT = TW'(THR_RESET);
  localparam logic [TW-1:0] STEP     = TW'(RAMP_STEP);
  localparam logic [GW-1:0] MAG_MAX  = GW'((1 << (WIDTH - 1)) - 1);

  localparam logic [1:0] MODE_SOFT   = 2'b01;
  localparam logic [1:0] MODE_BYPASS = 2'b10;

  typedef enum logic [0:0] {
    ST_STEADY = 1'b0,
    ST_RAMP   = 1'b1
  } state_t;

  state_t         state, next_state;
  logic [TW-1:0]  active_thr, next_thr, step_thr, tgt;

  // Stage 1 registers
  logic           s1_valid;
  logic [GW-1:0]  s1_g;
  logic [1:0]     s1_mode;
  logic [TW-1:0]  s1_thr;
  logic [WIDTH-1:0] s1_raw;

  // Stage 2 registers
  logic           s2_valid;
  logic           s2_bypass;
  logic           s2_neg;
  logic [TW-1:0]  s2_mag;
  logic [WIDTH-1:0] s2_raw;

  // Gain path
  logic [SW-1:0]  shift_eff;
  logic [GW-1:0]  in_ext, g_next;

  // Clip path
  logic           g_neg, g_over;
  logic [GW-1:0]  abs_g, thr_ext, excess, soft_mag, clip_mag;

  // Shift counts above MAX_SHIFT saturate; skipped when the port cannot exceed it.
  if (MAX_SHIFT < (1 << SW) - 1) begin : g_shift_clamp
    assign shift_eff = (gain_shift > SW'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : gain_shift;
  end else begin : g_shift_pass
    assign shift_eff = gain_shift;
  end

  assign in_ext = {{MAX_SHIFT{input_frame[WIDTH-1]}}, input_frame};
  assign g_next = in_ext << shift_eff;

  // Target clamp: zero threshold would make clipping degenerate, so floor at 1.
  assign tgt = (threshold == '0) ? TW'(1) : threshold;

  // One slew step from the active threshold toward the target, never overshooting.
  always_comb begin
    step_thr = active_thr;
    if (active_thr < tgt) begin
      step_thr = ((tgt - active_thr) > STEP) ? (active_thr + STEP) : tgt;
    end else if (active_thr > tgt) begin
      step_thr = ((active_thr - tgt) > STEP) ? (active_thr - STEP) : tgt;
    end
  end

  // Slew FSM next-state: enter RAMP on any mismatch, step only on accepted samples.
  always_comb begin
    next_state = state;
    next_thr   = active_thr;
    ramping    = 1'b0;
    case (state)
      ST_STEADY: begin
        if (tgt != active_thr) next_state = ST_RAMP;
      end
      ST_RAMP: begin
        ramping = 1'b1;
        if (in_valid) next_thr = step_thr;
        if (next_thr == tgt) next_state = ST_STEADY;
      end
      default: next_state = ST_STEADY;
    endcase
  end

  // Slew FSM state and active threshold registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_STEADY;
      active_thr <= THR_INIT;
    end else begin
      state      <= next_state;
      active_thr <= next_thr;
    end
  end

  // Stage 1: capture gained sample with the pre-update threshold and mode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_mode  <= '0;
      s1_thr   <= '0;
      s1_raw   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_g    <= g_next;
        s1_mode <= mode;
        s1_thr  <= active_thr;
        s1_raw  <= input_frame;
      end
    end
  end

  // Clip magnitude: work on |g| so the result is symmetric by construction.
  always_comb begin
    g_neg    = s1_g[GW-1];
    abs_g    = g_neg ? (~s1_g + GW'(1)) : s1_g;
    thr_ext  = {{(GW-TW){1'b0}}, s1_thr};
    g_over   = abs_g > thr_ext;
    excess   = abs_g - thr_ext;
    soft_mag = g_over ? (thr_ext + (excess >> 2)) : abs_g;
    if (soft_mag > MAG_MAX) soft_mag = MAG_MAX;
    clip_mag = g_over ? thr_ext : abs_g;
    if (s1_mode == MODE_SOFT) clip_mag = soft_mag;
  end

  // Stage 2: register clipped magnitude, sign and bypass selection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s2_valid  <= 1'b0;
      s2_bypass <= 1'b0;
      s2_neg    <= 1'b0;
      s2_mag    <= '0;
      s2_raw    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bypass <= (s1_mode == MODE_BYPASS);
        s2_neg    <= g_neg;
        s2_mag    <= TW'(clip_mag);
        s2_raw    <= s1_raw;
      end
    end
  end

  // Output register: apply sign, or pass the raw sample in bypass; hold otherwise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid    <= 1'b0;
      output_frame <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        if (s2_bypass)   output_frame <= s2_raw;
        else if (s2_neg) output_frame <= ~{1'b0, s2_mag} + WIDTH'(1);
        else             output_frame <= {1'b0, s2_mag};
      end
    end
  end

endmodule

// File: tb/tb_overdrive_multi.sv
// Testbench for overdrive_multi: directed vectors with hand-computed results,
// an expected-value queue filled by the driver and drained by an output monitor.
module tb_overdrive_multi;

  localparam int WIDTH = 16;

  localparam logic [1:0] HARD = 2'b00;
  localparam logic [1:0] SOFT = 2'b01;
  localparam logic [1:0] BYP  = 2'b10;
  localparam logic [1:0] RSV  = 2'b11;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             in_valid;
  logic [WIDTH-1:0] input_frame;
  logic [1:0]       gain_shift;
  logic [1:0]       mode;
  logic [WIDTH-2:0] threshold;
  logic             out_valid;
  logic [WIDTH-1:0] output_frame;
  logic             ramping;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  overdrive_multi dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .in_valid     (in_valid),
    .input_frame  (input_frame),
    .gain_shift   (gain_shift),
    .mode         (mode),
    .threshold    (threshold),
    .out_valid    (out_valid),
    .output_frame (output_frame),
    .ramping      (ramping)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one sample for one clock and record its expected output and arrival cycle.
  task automatic send(input logic [1:0] md, input logic [1:0] gs, input int x, input int e);
    in_valid    = 1'b1;
    mode        = md;
    gain_shift  = gs;
    input_frame = WIDTH'(x);
    exp_q.push_back(WIDTH'(e));
    exp_cyc_q.push_back(cyc + 3);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs still pending expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // Samples that would surface at or after the upcoming reset edge are discarded.
  task automatic flush_for_reset();
    while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
      void'(exp_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
  endtask

  // Monitor: every out_valid strobe must match the oldest expected sample and its cycle.
  always @(negedge CLK) begin
    logic [WIDTH-1:0] e;
    int               c;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0d expected no output (cycle %0d)",
                 $signed(output_frame), cyc);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("output_frame", $signed(output_frame), $signed(e));
        chk("out_cycle", cyc, c);
      end
    end
  end

  // Stimulus
  initial begin
    RESET       = 1'b1;
    in_valid    = 1'b1;
    input_frame = WIDTH'(1234);
    mode        = HARD;
    gain_shift  = 2'd0;
    threshold   = 15'd15000;

    // Reset with in_valid held high: nothing may come out.
    repeat (2) begin
      tick();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_output_frame", $signed(output_frame), 0);
      chk("rst_ramping", int'(ramping), 0);
    end
    RESET    = 1'b0;
    in_valid = 1'b0;

    // Active threshold after reset, observed through a saturating hard clip.
    send(HARD, 2'd3, 32767, 15000);

    // Hard clip, gain x4, back to back.
    send(HARD, 2'd2, 1000, 4000);
    send(HARD, 2'd2, 5000, 15000);
    send(HARD, 2'd2, -5000, -15000);
    send(HARD, 2'd2, -32768, -15000);
    send(RSV,  2'd2, 5000, 15000);

    // Soft clip.
    send(SOFT, 2'd2, 5000, 16250);
    send(SOFT, 2'd2, -5000, -16250);
    send(SOFT, 2'd3, 32767, 32767);
    send(SOFT, 2'd0, 100, 100);

    // Bypass, then mode and gain switches on a back-to-back stream.
    send(BYP,  2'd3, -32768, -32768);
    send(BYP,  2'd3, 1000, 1000);
    send(HARD, 2'd2, 1000, 4000);
    send(HARD, 2'd0, 3000, 3000);
    send(HARD, 2'd1, 3000, 6000);
    drain();

    // Upward ramp 15000 -> 16000; each sample sees the pre-update threshold.
    threshold = 15'd16000;
    idle(1);
    chk("ramp_up_start", int'(ramping), 1);
    send(HARD, 2'd3, 32767, 15000);
    send(HARD, 2'd3, 32767, 15256);
    send(HARD, 2'd3, 32767, 15512);
    chk("ramp_up_mid", int'(ramping), 1);
    send(HARD, 2'd3, 32767, 15768);
    chk("ramp_up_done", int'(ramping), 0);
    send(HARD, 2'd3, 32767, 16000);

    // Frozen while idle, then redirected mid-ramp.
    in_valid  = 1'b0;
    threshold = 15'd17000;
    idle(100);
    chk("ramp_frozen", int'(ramping), 1);
    send(HARD, 2'd3, 32767, 16000);
    send(HARD, 2'd3, 32767, 16256);
    in_valid  = 1'b0;
    threshold = 15'd16300;
    idle(1);
    send(HARD, 2'd3, 32767, 16512);
    chk("redirect_done", int'(ramping), 0);
    send(HARD, 2'd3, 32767, 16300);
    drain();

    // Target 0 clamps to 1.
    in_valid  = 1'b0;
    threshold = 15'd0;
    idle(1);
    chk("ramp_to_min", int'(ramping), 1);
    repeat (70) send(HARD, 2'd0, 0, 0);
    send(HARD, 2'd3, 32767, 1);
    send(HARD, 2'd3, -32768, -1);
    chk("min_reached", int'(ramping), 0);

    // Target full scale; clipping stays symmetric.
    in_valid  = 1'b0;
    threshold = 15'd32767;
    idle(1);
    repeat (135) send(HARD, 2'd0, 0, 0);
    send(HARD, 2'd3, 32767, 32767);
    send(HARD, 2'd0, -32768, -32767);
    send(SOFT, 2'd3, -32768, -32767);
    chk("max_reached", int'(ramping), 0);
    drain();

    // Reset mid-ramp discards in-flight samples and restores the threshold.
    threshold = 15'd15000;
    idle(1);
    chk("ramp_down_start", int'(ramping), 1);
    repeat (3) send(HARD, 2'd0, 0, 0);
    send(HARD, 2'd3, 32767, 31999);
    RESET       = 1'b1;
    in_valid    = 1'b1;
    input_frame = WIDTH'(5000);
    flush_for_reset();
    repeat (2) begin
      tick();
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_output_frame", $signed(output_frame), 0);
      chk("midrst_ramping", int'(ramping), 0);
    end
    RESET    = 1'b0;
    in_valid = 1'b0;
    send(HARD, 2'd3, 32767, 15000);
    chk("post_rst_ramping", int'(ramping), 0);
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
